// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg: shared FSM states, parity codes and parity helper for the UART transmitter
package uart_tx_mmio_pkg;
    typedef enum logic [2:0] {UTX_IDLE, UTX_START, UTX_DATA, UTX_PARITY, UTX_STOP} utx_state_e;
    localparam int UTX_PAR_NONE = 0;
    localparam int UTX_PAR_EVEN = 1;
    localparam int UTX_PAR_ODD  = 2;
    function automatic logic parity_bit(input logic [8:0] d, input int mode);
        return mode == UTX_PAR_ODD ? ~^d : ^d;
    endfunction
endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// uart_fifo: synchronous first-word-fall-through FIFO with occupancy count
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     sysclk,
    input  logic                     cpu_resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop & ~empty;
    // a full FIFO still accepts a push when the head leaves on the same edge
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge sysclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter with transmit FIFO and status flags
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0
) (
    input  logic                          sysclk,
    input  logic                          cpu_resetn,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          clr_overflow,
    output logic                          uart_tx,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_busy,
    output logic                          overflow
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    utx_state_e state, state_n;
    logic [CW-1:0] baud, baud_n;
    logic [BW-1:0] idx, idx_n;
    logic [DATA_BITS-1:0] data, data_n, head;
    logic pop, line, tick, last_data, last_stop;
    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .sysclk(sysclk),
        .cpu_resetn(cpu_resetn),
        .push(wr_en),
        .pop(pop),
        .din(wr_data),
        .dout(head),
        .count(fifo_count),
        .full(fifo_full),
        .empty(fifo_empty)
    );
    assign tick      = baud == CW'(CLKS_PER_BIT - 1);
    assign last_data = idx == BW'(DATA_BITS - 1);
    assign last_stop = idx == BW'(STOP_BITS - 1);
    assign tx_busy   = (state != UTX_IDLE) | ~fifo_empty;
    always_comb begin
        state_n = state;
        baud_n  = tick ? '0 : baud + 1'b1;
        idx_n   = idx;
        data_n  = data;
        pop     = 1'b0;
        case (state)
            UTX_IDLE: begin
                baud_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_n  = head;
                    state_n = UTX_START;
                end
            end
            UTX_START:  if (tick) state_n = UTX_DATA;
            UTX_DATA: begin
                if (tick) begin
                    idx_n = last_data ? '0 : idx + 1'b1;
                    if (last_data) state_n = PARITY != UTX_PAR_NONE ? UTX_PARITY : UTX_STOP;
                end
            end
            UTX_PARITY: if (tick) state_n = UTX_STOP;
            UTX_STOP: begin
                if (tick) begin
                    idx_n = last_stop ? '0 : idx + 1'b1;
                    // chain straight into the next start bit when more data is queued
                    if (last_stop) begin
                        pop     = ~fifo_empty;
                        data_n  = fifo_empty ? data : head;
                        state_n = fifo_empty ? UTX_IDLE : UTX_START;
                    end
                end
            end
            default: state_n = UTX_IDLE;
        endcase
    end
    always_comb begin
        line = state == UTX_START  ? 1'b0 :
               state == UTX_DATA   ? data[idx] :
               state == UTX_PARITY ? parity_bit(9'(data), PARITY) : 1'b1;
    end
    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state    <= UTX_IDLE;
            baud     <= '0;
            idx      <= '0;
            data     <= '0;
            uart_tx  <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            idx     <= idx_n;
            data    <= data_n;
            uart_tx <= line;
            if (wr_en & fifo_full & ~pop) overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: randomized scoreboard bench with a frame-level reference model and serial receiver
module tb_uart_tx_mmio;
    localparam int CPB = 4, DEPTH = 4, F = CPB * 10;
    logic clk = 0, rst_n = 0, wr_en = 0, clr = 0;
    logic [7:0] wr_data = 0;
    logic uart_tx, fifo_full, fifo_empty, tx_busy, overflow;
    logic [2:0] fifo_count;
    logic wr2 = 0, tx2, full2, empty2, busy2, ovf2;
    logic [6:0] d2 = 0;
    logic [2:0] cnt2;
    typedef struct {logic [7:0] d; int t;} frame_t;
    frame_t exp_q[$];
    logic [7:0] m_q[$];
    int cyc = 0, m_ready = 0, checks = 0, errors = 0;
    bit m_ovf = 0, m_busy = 0;

    uart_tx_mmio #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY(0)) dut (
        .sysclk(clk), .cpu_resetn(rst_n), .wr_en(wr_en), .wr_data(wr_data), .clr_overflow(clr),
        .uart_tx(uart_tx), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .tx_busy(tx_busy), .overflow(overflow));
    uart_tx_mmio #(.DATA_BITS(7), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY(2)) dut2 (
        .sysclk(clk), .cpu_resetn(rst_n), .wr_en(wr2), .wr_data(d2), .clr_overflow(1'b0),
        .uart_tx(tx2), .fifo_full(full2), .fifo_empty(empty2), .fifo_count(cnt2),
        .tx_busy(busy2), .overflow(ovf2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: a pop happens once the previous frame has had its full duration
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            exp_q.delete();
            m_ovf = 0;
            m_busy = 0;
            m_ready = cyc;
        end else begin
            bit pop_now, push_ok;
            pop_now = m_q.size() > 0 && cyc >= m_ready;
            push_ok = wr_en && (m_q.size() < DEPTH || pop_now);
            if (pop_now) begin
                exp_q.push_back('{d: m_q.pop_front(), t: cyc + 2});
                m_ready = cyc + F;
            end
            if (push_ok) m_q.push_back(wr_data);
            if (wr_en && !push_ok) m_ovf = 1;
            else if (clr) m_ovf = 0;
            m_busy = m_q.size() > 0 || cyc < m_ready;
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", fifo_count, m_q.size());
            chk("full", fifo_full, m_q.size() == DEPTH);
            chk("empty", fifo_empty, m_q.size() == 0);
            chk("overflow", overflow, m_ovf);
            chk("busy", tx_busy, m_busy);
        end
    end

    // Serial receiver: every cycle of every bit is sampled so width and glitches are visible
    initial begin : rx_mon
        logic prev, smp[F];
        logic [7:0] got;
        bit abort, shape;
        int t0;
        frame_t e;
        prev = 1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1;
            end else if (prev && !uart_tx) begin
                t0 = cyc;
                abort = 0;
                smp[0] = uart_tx;
                for (int k = 1; k < F; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        abort = 1;
                        break;
                    end
                    smp[k] = uart_tx;
                end
                if (abort) begin
                    prev = 1;
                end else begin
                    shape = smp[0] === 1'b0 && smp[F-CPB] === 1'b1;
                    for (int b = 0; b < 10; b++)
                        for (int c = 1; c < CPB; c++)
                            if (smp[b*CPB+c] !== smp[b*CPB]) shape = 0;
                    for (int i = 0; i < 8; i++) got[i] = smp[(i+1)*CPB];
                    chk("frame_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("frame_shape", shape, 1);
                        chk("frame_data", got, e.d);
                        chk("frame_start_cycle", t0, e.t);
                    end
                    prev = smp[F-1];
                end
            end else begin
                prev = uart_tx;
            end
        end
    end

    task automatic put(input logic [7:0] d);
        wr_en = 1;
        wr_data = d;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic pulse_clr();
        clr = 1;
        @(negedge clk);
        clr = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_q.size() > 0 || m_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : stim
        logic bits2[22];
        logic [6:0] b2[2];
        int n;
        repeat (3) @(negedge clk);
        chk("rst_tx", uart_tx, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_ovf", overflow, 0);
        #2 rst_n = 1;
        @(negedge clk);
        put(8'h55);
        wait_idle(200);
        put(8'h41);
        put(8'h42);
        wait_idle(300);
        repeat (6) put(8'($urandom));
        chk("t3_ovf", overflow, 1);
        chk("t3_full", fifo_full, 1);
        wait_idle(500);
        pulse_clr();
        chk("t3_ovf_clr", overflow, 0);
        repeat (5) put(8'($urandom));
        n = 0;
        while (cyc != m_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        put(8'($urandom));
        chk("t4_count", fifo_count, 4);
        chk("t4_no_ovf", overflow, 0);
        put(8'($urandom));
        chk("t4_drop_ovf", overflow, 1);
        wr_en = 1;
        clr = 1;
        @(negedge clk);
        wr_en = 0;
        clr = 0;
        chk("t4_set_beats_clr", overflow, 1);
        pulse_clr();
        chk("t4_clr", overflow, 0);
        wait_idle(500);
        for (int i = 0; i < 400; i++) begin
            wr_en = $urandom_range(0, 99) < 35;
            wr_data = 8'($urandom);
            clr = $urandom_range(0, 19) == 0;
            @(negedge clk);
        end
        wr_en = 0;
        clr = 0;
        wait_idle(2000);
        chk("all_frames_seen", exp_q.size(), 0);
        b2[0] = 7'h07;
        b2[1] = 7'($urandom);
        for (int j = 0; j < 2; j++) begin
            bits2[11*j] = 0;
            for (int i = 0; i < 7; i++) bits2[11*j+1+i] = b2[j][i];
            bits2[11*j+8] = ~^b2[j];
            bits2[11*j+9] = 1;
            bits2[11*j+10] = 1;
        end
        wr2 = 1;
        d2 = b2[0];
        @(negedge clk);
        d2 = b2[1];
        @(negedge clk);
        wr2 = 0;
        for (int k = 0; k < 22; k++) begin
            repeat (k == 0 ? 3 : 4) @(negedge clk);
            chk($sformatf("p2_bit%0d", k), tx2, bits2[k]);
        end
        repeat (2) @(negedge clk);
        chk("p2_busy_fall", busy2, 0);
        put(8'($urandom));
        put(8'($urandom));
        put(8'($urandom));
        repeat (18) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_tx", uart_tx, 1);
        chk("rst_mid_count", fifo_count, 0);
        chk("rst_mid_busy", tx_busy, 0);
        chk("rst_mid_empty", fifo_empty, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        repeat (60) @(negedge clk);
        chk("post_rst_line", uart_tx, 1);
        chk("post_rst_busy", tx_busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
